// File: rtl/gen_source.sv
// rtl/gen_source.sv - valid/ready burst source with inter-beat idle gap.
// Define GEN_SOURCE_LFSR_EN to emit a 16-bit LFSR sequence instead of a counter.
module gen_source #(
  parameter int          DW    = 16,
  parameter int          DELAY = 1,
  parameter int unsigned START = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   num_beats,
  output logic          down_valid,
  output logic [DW-1:0] down_data,
  input  logic          down_ready,
  output logic          busy,
  output logic          done
);

  localparam int GW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

`ifdef GEN_SOURCE_LFSR_EN
  localparam int            RW   = 16;
  localparam logic [RW-1:0] SEED = 16'hACE1;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [RW-1:0] advance(input logic [RW-1:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction
`else
  localparam int            RW   = DW;
  localparam logic [RW-1:0] SEED = RW'(START);

  function automatic logic [RW-1:0] advance(input logic [RW-1:0] v);
    return v + RW'(1);
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

  state_t        state_q, state_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] data_q, data_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    data_d      = data_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = num_beats;
          data_d      = SEED;
          if (num_beats == 16'd0) begin
            done_d = 1'b1;
          end else if (DELAY == 0) begin
            state_d = SEND;
          end else begin
            state_d = GAP;
            gap_d   = GW'(DELAY);
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (down_ready) begin
          remaining_d = remaining_q - 16'd1;
          data_d      = advance(data_q);
          if (remaining_q == 16'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (DELAY != 0) begin
            state_d = GAP;
            gap_d   = GW'(DELAY);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid and data come straight from flops, so ready never reaches them combinationally.
  assign down_valid = (state_q == SEND);
  assign down_data  = DW'(data_q);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_gen_source.sv
// tb/tb_gen_source.sv - directed self-checking bench for gen_source.
module tb_gen_source;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 0, start2 = 0, start4 = 0;
  logic [15:0] num0 = 0, num2 = 0, num4 = 0;
  logic        ready0 = 1, ready2 = 1, ready4 = 1;
  logic        valid0, valid2, valid4;
  logic [15:0] data0, data2;
  logic [3:0]  data4;
  logic        busy0, busy2, busy4, done0, done2, done4;

  int n_checks = 0;
  int n_fail   = 0;

  gen_source #(.DW(16), .DELAY(0), .START(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .num_beats(num0),
    .down_valid(valid0), .down_data(data0), .down_ready(ready0),
    .busy(busy0), .done(done0));

  gen_source #(.DW(16), .DELAY(2), .START(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .num_beats(num2),
    .down_valid(valid2), .down_data(data2), .down_ready(ready2),
    .busy(busy2), .done(done2));

  gen_source #(.DW(4), .DELAY(0), .START(14)) u4 (
    .clk(clk), .rst(rst), .start(start4), .num_beats(num4),
    .down_valid(valid4), .down_data(data4), .down_ready(ready4),
    .busy(busy4), .done(done4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected k-th beat of a burst for a given width/seed.
  function automatic logic [31:0] model(input int dw, input int unsigned st, input int k);
    logic [31:0] v;
`ifdef GEN_SOURCE_LFSR_EN
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < k; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    v = {16'd0, l};
`else
    v = st + k;
`endif
    return v & ((32'd1 << dw) - 1);
  endfunction

  logic [15:0] exp1 [4];
  logic        pat [5];
  int          acc;

  initial begin
`ifdef GEN_SOURCE_LFSR_EN
    exp1[0] = 16'hACE1; exp1[1] = 16'h5670; exp1[2] = 16'hAB38; exp1[3] = 16'h559C;
`else
    exp1[0] = 16'd0; exp1[1] = 16'd1; exp1[2] = 16'd2; exp1[3] = 16'd3;
`endif
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;

    // Reset state
    tick();
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    rst = 1;
    tick();

    // Back-to-back burst of 4, DELAY=0
    start0 = 1; num0 = 4;
    tick();
    start0 = 0; num0 = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b4_valid%0d", i), valid0, 1);
      chk($sformatf("b4_data%0d", i), data0, exp1[i]);
      chk($sformatf("b4_busy%0d", i), busy0, 1);
      tick();
    end
    chk("b4_end_valid", valid0, 0);
    chk("b4_end_busy", busy0, 0);
    chk("b4_done", done0, 1);
    tick();
    chk("b4_done_pulse", done0, 0);

    // DELAY=2, 3 beats
    start2 = 1; num2 = 3;
    tick();
    start2 = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gap_a%0d", i), valid2, 0);
      chk($sformatf("gap_busy%0d", i), busy2, 1);
      tick();
      chk($sformatf("gap_b%0d", i), valid2, 0);
      tick();
      chk($sformatf("gap_valid%0d", i), valid2, 1);
      chk($sformatf("gap_data%0d", i), data2, model(16, 0, i));
      tick();
    end
    chk("gap_done", done2, 1);
    chk("gap_end_busy", busy2, 0);
    tick();

    // Backpressure 1,0,0,1,1: accepted beats 0,1,2 with stalls on beat 1
    start0 = 1; num0 = 3;
    tick();
    start0 = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      ready0 = pat[i];
      chk($sformatf("bp_valid%0d", i), valid0, 1);
      chk($sformatf("bp_data%0d", i), data0, model(16, 0, acc));
      if (pat[i]) acc++;
      tick();
    end
    ready0 = 1;
    chk("bp_done", done0, 1);
    chk("bp_end_valid", valid0, 0);
    tick();

    // DW=4 wrap, start while busy ignored
    start4 = 1; num4 = 4;
    tick();
    start4 = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_valid%0d", i), valid4, 1);
      chk($sformatf("wr_data%0d", i), data4, model(4, 14, i));
      if (i == 1) begin start4 = 1; num4 = 9; end
      tick();
      start4 = 0;
    end
    chk("wr_done", done4, 1);
    chk("wr_end_valid", valid4, 0);
    tick();
    chk("wr_idle_busy", busy4, 0);

    // num_beats = 0
    start4 = 1; num4 = 0;
    tick();
    start4 = 0;
    chk("z_done", done4, 1);
    chk("z_valid", valid4, 0);
    chk("z_busy", busy4, 0);
    tick();
    chk("z_done_pulse", done4, 0);
    chk("z_valid2", valid4, 0);

    // Asynchronous reset during beat 2 of 5
    start0 = 1; num0 = 5;
    tick();
    start0 = 0;
    chk("ar_beat0", data0, model(16, 0, 0));
    tick();
    chk("ar_beat1_valid", valid0, 1);
    #2 rst = 0;
    #1;
    chk("ar_valid", valid0, 0);
    chk("ar_busy", busy0, 0);
    chk("ar_done", done0, 0);
    tick();
    chk("ar_hold_done", done0, 0);
    rst = 1;
    tick();
    start0 = 1; num0 = 2;
    tick();
    start0 = 0;
    chk("ar_re_valid", valid0, 1);
    chk("ar_re_data0", data0, model(16, 0, 0));
    tick();
    chk("ar_re_data1", data0, model(16, 0, 1));
    tick();
    chk("ar_re_done", done0, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_source.md
# gen_source

Stream source for the test harness: on a start pulse it emits a programmed number of data beats on a valid/ready output, with a fixed idle gap of DELAY cycles between beats. It is the producer counterpart of the checker path and drives the checker's upstream port directly. Data is an incrementing sequence (or LFSR sequence when configured), so the checker can predict every beat.

## Interface
- DW, 16, data width in bits (≥ 1)
- DELAY, 1, idle cycles inserted before each beat (≥ 0)
- START, 0, first data value after reset/start (DW bits)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst
- num_beats  in  16  beats in the burst, sampled when start is accepted
- down_valid  out  1  beat valid
- down_data  out  DW  beat data
- down_ready  in  1  sink ready
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when burst completes

## Operation
- FSM states: IDLE, GAP, SEND.
- IDLE: busy=0. start=1 → latch num_beats into remaining counter, load data register with seed (START, or LFSR seed); if num_beats=0 → pulse done next cycle, stay IDLE; else DELAY=0 → SEND, DELAY>0 → GAP with gap counter=DELAY.
- GAP: down_valid=0; decrement gap counter each cycle; at 1 → SEND.
- SEND: down_valid=1, down_data = data register. On handshake (down_valid & down_ready): remaining−1; advance data register; if remaining was 1 → IDLE, done=1 next cycle; else DELAY=0 → stay SEND, DELAY>0 → GAP.
- Data advance: data+1 modulo 2^DW (all-ones wraps to 0).
- start while busy ignored; num_beats not resampled.
- Handshake rules: down_valid, once high, stays high with down_data stable until accepted. down_valid/down_data driven from registers only; no combinational path down_ready → outputs.
- busy=1 in GAP and SEND.
- Data register persists across bursts? No: reloaded with seed at every accepted start.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, down_valid=0, down_data=0, busy=0, done=0, counters=0. Reset mid-burst aborts immediately; no done pulse.
- start at cycle t (IDLE): busy=1 from t+1. First down_valid at t+1 (DELAY=0) or t+1+DELAY.
- Handshake at cycle h, not last: next down_valid at h+1 (DELAY=0, throughput 1 beat/cycle) or h+1+DELAY.
- Last handshake at h: down_valid=0, busy=0, done=1 at h+1; a start at h+1 is accepted.
- num_beats=0: done=1 at t+1, busy stays 0, no beats.
- down_ready held low: FSM stalls in SEND indefinitely, outputs frozen.
- Counters: remaining 16 bits; gap counter $clog2(DELAY+1) bits (min 1).

## Configuration
- GEN_SOURCE_LFSR_EN defined: data register is a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 loaded on start (START ignored); down_data = LFSR value zero-extended or truncated to DW; advance = one LFSR shift per handshake.
- Not defined: incrementing counter seeded from START as above.

## Test plan
- DW=16, DELAY=0, START=0, num_beats=4, down_ready=1 → beats 0,1,2,3 on four consecutive cycles from t+1; done=1 at cycle after beat 3; busy high exactly 4 cycles.
- DELAY=2, num_beats=3, down_ready=1 → each beat preceded by 2 cycles of down_valid=0; first valid at t+3; data 0,1,2.
- DELAY=0, num_beats=3, down_ready toggling 1,0,0,1,1 → valid never drops while pending, data stable during stalls; accepted sequence 0,1,2.
- DW=4, START=14, num_beats=4 → data 14,15,0,1 (wrap); start pulsed mid-burst ignored; num_beats=0 → done one cycle later, no valid.
- rst asserted low during beat 2 of 5 → down_valid, busy, done go 0 immediately; after release, new start restarts from START.
- GEN_SOURCE_LFSR_EN, DW=16, num_beats=3 → data 16'hACE1 then next two LFSR states per polynomial; checker-side model matches.
